// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU-side and response signals of the ALU command issuer
interface alu_cmd_issuer_if #(
  parameter int WIDTH     = 16,
  parameter int FUN_WIDTH = 4
);
  // Command channel
  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [FUN_WIDTH-1:0] CMD_FUN;
  logic [WIDTH-1:0]     CMD_A;
  logic [WIDTH-1:0]     CMD_B;
  // ALU drive and return
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [FUN_WIDTH-1:0] ALU_FUN;
  logic [WIDTH-1:0]     ALU_OUT;
  logic                 Arith_flag;
  logic                 Logic_flag;
  logic                 CMP_flag;
  logic                 Shift_flag;
  // Response channel and statistics
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [WIDTH-1:0]     RSP_DATA;
  logic [3:0]           RSP_FLAGS;
  logic                 RSP_ERR;
  logic [15:0]          OP_COUNT;

  // Issuer side
  modport slave (
    input  CMD_VALID, CMD_FUN, CMD_A, CMD_B,
    input  ALU_OUT, Arith_flag, Logic_flag, CMP_flag, Shift_flag,
    input  RSP_READY,
    output CMD_READY, A, B, ALU_FUN,
    output RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR, OP_COUNT
  );

  // Command source, ALU and response consumer side
  modport master (
    output CMD_VALID, CMD_FUN, CMD_A, CMD_B,
    output ALU_OUT, Arith_flag, Logic_flag, CMP_flag, Shift_flag,
    output RSP_READY,
    input  CMD_READY, A, B, ALU_FUN,
    input  RSP_VALID, RSP_DATA, RSP_FLAGS, RSP_ERR, OP_COUNT
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - issues one ALU operation at a time and returns a checked response
module alu_cmd_issuer #(
  parameter int WIDTH     = 16,
  parameter int FUN_WIDTH = 4
) (
  input logic           CLK,
  input logic           RST,
  alu_cmd_issuer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [FUN_WIDTH-1:0] FUN_DIV   = FUN_WIDTH'(3);
  localparam logic [FUN_WIDTH-1:0] FUN_LOGLO = FUN_WIDTH'(4);
  localparam logic [FUN_WIDTH-1:0] FUN_CMPLO = FUN_WIDTH'(10);
  localparam logic [FUN_WIDTH-1:0] FUN_SHFLO = FUN_WIDTH'(13);
  localparam logic [FUN_WIDTH-1:0] FUN_NOP   = '1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [FUN_WIDTH-1:0] fun_q, fun_d;
  logic                 div0_q, div0_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [3:0]           rsp_flags_q, rsp_flags_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [15:0]          op_count_q, op_count_d;

  logic [3:0]           flags_in;
  logic [3:0]           exp_flags;

  assign flags_in = {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag};

  // Flag class the ALU should report for the opcode currently being issued
  always_comb begin
    exp_flags = 4'b0000;
    if (fun_q < FUN_LOGLO)      exp_flags = 4'b1000;
    else if (fun_q < FUN_CMPLO) exp_flags = 4'b0100;
    else if (fun_q < FUN_SHFLO) exp_flags = 4'b0010;
    else if (fun_q != FUN_NOP)  exp_flags = 4'b0001;
  end

  // FSM state register; reset discards any in-flight operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and next datapath values; everything holds unless the state says otherwise
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    div0_d      = div0_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.CMD_VALID) begin
          a_d     = bus.CMD_A;
          b_d     = bus.CMD_B;
          fun_d   = bus.CMD_FUN;
          div0_d  = (bus.CMD_FUN == FUN_DIV) && (bus.CMD_B == '0);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // ALU output registered at the ISSUE closing edge is valid now
        rsp_data_d  = div0_q ? '0 : bus.ALU_OUT;
        rsp_flags_d = flags_in;
        rsp_err_d   = (flags_in != exp_flags) || div0_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          rsp_valid_d = 1'b0;
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; ALU_FUN parks on the no-op code while in reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= FUN_NOP;
      div0_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= 4'b0000;
      rsp_err_q   <= 1'b0;
      op_count_q  <= 16'd0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      div0_q      <= div0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.CMD_READY = (state_q == S_IDLE);
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_FUN   = fun_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.RSP_FLAGS = rsp_flags_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.OP_COUNT  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed bench for alu_cmd_issuer with a registered ALU model
module tb_alu_cmd_issuer;

  logic CLK;
  logic RST;
  logic alu_bad;
  int   n_total;
  int   n_pass;
  int   n_fail;
  logic [15:0] exp_count;

  alu_cmd_issuer_if #(.WIDTH(16), .FUN_WIDTH(4)) bus ();

  alu_cmd_issuer #(.WIDTH(16), .FUN_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered 16-bit ALU model; alu_bad makes ADD report the Logic class
  logic [15:0] alu_r;
  logic [3:0]  alu_f;
  always_comb begin
    alu_r = 16'h0000;
    alu_f = 4'b0000;
    case (bus.ALU_FUN)
      4'd0:  begin alu_r = bus.A + bus.B; alu_f = 4'b1000; end
      4'd1:  begin alu_r = bus.A - bus.B; alu_f = 4'b1000; end
      4'd2:  begin alu_r = bus.A * bus.B; alu_f = 4'b1000; end
      4'd3:  begin alu_r = (bus.B == 16'd0) ? 16'hFFFF : bus.A / bus.B; alu_f = 4'b1000; end
      4'd4:  begin alu_r = bus.A & bus.B;    alu_f = 4'b0100; end
      4'd5:  begin alu_r = bus.A | bus.B;    alu_f = 4'b0100; end
      4'd6:  begin alu_r = ~(bus.A & bus.B); alu_f = 4'b0100; end
      4'd7:  begin alu_r = ~(bus.A | bus.B); alu_f = 4'b0100; end
      4'd8:  begin alu_r = bus.A ^ bus.B;    alu_f = 4'b0100; end
      4'd9:  begin alu_r = ~(bus.A ^ bus.B); alu_f = 4'b0100; end
      4'd10: begin alu_r = (bus.A == bus.B) ? 16'd1 : 16'd0; alu_f = 4'b0010; end
      4'd11: begin alu_r = (bus.A >  bus.B) ? 16'd2 : 16'd0; alu_f = 4'b0010; end
      4'd12: begin alu_r = (bus.A <  bus.B) ? 16'd3 : 16'd0; alu_f = 4'b0010; end
      4'd13: begin alu_r = bus.A >> 1; alu_f = 4'b0001; end
      4'd14: begin alu_r = bus.A << 1; alu_f = 4'b0001; end
      default: begin alu_r = 16'h0000; alu_f = 4'b0000; end
    endcase
    if (alu_bad && bus.ALU_FUN == 4'd0) alu_f = 4'b0100;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.ALU_OUT    <= 16'h0000;
      bus.Arith_flag <= 1'b0;
      bus.Logic_flag <= 1'b0;
      bus.CMP_flag   <= 1'b0;
      bus.Shift_flag <= 1'b0;
    end else begin
      bus.ALU_OUT    <= alu_r;
      bus.Arith_flag <= alu_f[3];
      bus.Logic_flag <= alu_f[2];
      bus.CMP_flag   <= alu_f[1];
      bus.Shift_flag <= alu_f[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation with RSP_READY held high; checks timing and response fields
  task automatic do_op(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ed, input logic [3:0] ef, input logic ee);
    @(negedge CLK);
    chk("op_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_FUN   = fun;
    bus.CMD_A     = a;
    bus.CMD_B     = b;
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    chk("op_a_issued", 32'(bus.A), 32'(a));
    chk("op_b_issued", 32'(bus.B), 32'(b));
    chk("op_fun_issued", 32'(bus.ALU_FUN), 32'(fun));
    chk("op_valid_n1", 32'(bus.RSP_VALID), 32'd0);
    @(negedge CLK);
    chk("op_valid_n2", 32'(bus.RSP_VALID), 32'd0);
    @(negedge CLK);
    chk("op_valid_rise", 32'(bus.RSP_VALID), 32'd1);
    chk("op_data", 32'(bus.RSP_DATA), 32'(ed));
    chk("op_flags", 32'(bus.RSP_FLAGS), 32'(ef));
    chk("op_err", 32'(bus.RSP_ERR), 32'(ee));
    @(negedge CLK);
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    chk("op_valid_fall", 32'(bus.RSP_VALID), 32'd0);
    chk("op_count", 32'(bus.OP_COUNT), 32'(exp_count));
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    exp_count = 16'd0;
    alu_bad = 1'b0;
    RST = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_FUN   = 4'd0;
    bus.CMD_A     = 16'd0;
    bus.CMD_B     = 16'd0;
    bus.RSP_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_a", 32'(bus.A), 32'd0);
    chk("rst_b", 32'(bus.B), 32'd0);
    chk("rst_fun", 32'(bus.ALU_FUN), 32'hF);
    chk("rst_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_data", 32'(bus.RSP_DATA), 32'd0);
    chk("rst_flags", 32'(bus.RSP_FLAGS), 32'd0);
    chk("rst_err", 32'(bus.RSP_ERR), 32'd0);
    chk("rst_count", 32'(bus.OP_COUNT), 32'd0);
    RST = 1'b1;

    // Arithmetic, compare and shift operations
    do_op(4'b0000, 16'h0003, 16'h0004, 16'h0007, 4'b1000, 1'b0);
    do_op(4'b1011, 16'h0005, 16'h0003, 16'h0002, 4'b0010, 1'b0);
    do_op(4'b1110, 16'h8001, 16'h0000, 16'h0002, 4'b0001, 1'b0);
    do_op(4'b0101, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0100, 1'b0);
    // Divide by zero: data forced to 0, error raised
    do_op(4'b0011, 16'h000A, 16'h0000, 16'h0000, 4'b1000, 1'b1);

    // Response backpressure with a command held valid the whole time
    @(negedge CLK);
    bus.CMD_VALID = 1'b1;
    bus.CMD_FUN   = 4'b0000;
    bus.CMD_A     = 16'h0001;
    bus.CMD_B     = 16'h0002;
    bus.RSP_READY = 1'b0;
    @(negedge CLK);
    bus.CMD_A = 16'h0009;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      chk("stall_cmd_ready", 32'(bus.CMD_READY), 32'd0);
      chk("stall_valid", 32'(bus.RSP_VALID), 32'd1);
      chk("stall_data", 32'(bus.RSP_DATA), 32'h0003);
      chk("stall_flags", 32'(bus.RSP_FLAGS), 32'b1000);
      chk("stall_no_accept", 32'(bus.A), 32'h0001);
      @(negedge CLK);
    end
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    exp_count = exp_count + 16'd1;
    chk("stall_hs_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("stall_hs_idle", 32'(bus.CMD_READY), 32'd1);
    chk("stall_hs_count", 32'(bus.OP_COUNT), 32'(exp_count));
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    chk("stall_next_accept", 32'(bus.A), 32'h0009);
    repeat (2) @(negedge CLK);
    chk("stall_next_data", 32'(bus.RSP_DATA), 32'h000B);
    @(negedge CLK);
    exp_count = exp_count + 16'd1;
    chk("stall_next_count", 32'(bus.OP_COUNT), 32'(exp_count));

    // Wrong flag class from the ALU, then the legal no-op code
    alu_bad = 1'b1;
    do_op(4'b0000, 16'h0010, 16'h0001, 16'h0011, 4'b0100, 1'b1);
    alu_bad = 1'b0;
    do_op(4'b1111, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b0);

    // Reset during WAIT
    @(negedge CLK);
    bus.CMD_VALID = 1'b1;
    bus.CMD_FUN   = 4'b0001;
    bus.CMD_A     = 16'h0050;
    bus.CMD_B     = 16'h0010;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    exp_count = 16'd0;
    chk("rstw_fun", 32'(bus.ALU_FUN), 32'hF);
    chk("rstw_a", 32'(bus.A), 32'd0);
    chk("rstw_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rstw_count", 32'(bus.OP_COUNT), 32'(exp_count));
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rstw_no_rsp", 32'(bus.RSP_VALID), 32'd0);
    chk("rstw_idle", 32'(bus.CMD_READY), 32'd1);

    // Reset during RESP
    bus.RSP_READY = 1'b0;
    bus.CMD_VALID = 1'b1;
    bus.CMD_FUN   = 4'b0000;
    bus.CMD_A     = 16'h0020;
    bus.CMD_B     = 16'h0001;
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rstr_pre_valid", 32'(bus.RSP_VALID), 32'd1);
    RST = 1'b0;
    #1;
    chk("rstr_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rstr_data", 32'(bus.RSP_DATA), 32'd0);
    chk("rstr_fun", 32'(bus.ALU_FUN), 32'hF);
    chk("rstr_count", 32'(bus.OP_COUNT), 32'(exp_count));
    @(negedge CLK);
    RST = 1'b1;
    bus.RSP_READY = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rstr_count_after", 32'(bus.OP_COUNT), 32'(exp_count));

    // Saturation of the operation counter
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFE;
    do_op(4'b0000, 16'h0001, 16'h0001, 16'h0002, 4'b1000, 1'b0);
    do_op(4'b0000, 16'h0002, 16'h0002, 16'h0004, 4'b1000, 1'b0);
    chk("sat_hold", 32'(bus.OP_COUNT), 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Command-side front end for the 16-bit registered ALU.
- Accepts operation packets over a valid/ready command interface and drives the ALU's A, B and ALU_FUN inputs.
- Waits out the ALU's one-clock register latency, then captures ALU_OUT and the four class flags.
- Returns the result, a checked flag vector and an error bit over a valid/ready response interface, and counts completed operations.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU data width.
- FUN_WIDTH, 4, opcode width; must match ALU_FUN.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command packet present
- CMD_READY  out  1  issuer can accept a command
- CMD_FUN  in  FUN_WIDTH  requested opcode
- CMD_A  in  WIDTH  operand A
- CMD_B  in  WIDTH  operand B
- A  out  WIDTH  to ALU operand A
- B  out  WIDTH  to ALU operand B
- ALU_FUN  out  FUN_WIDTH  to ALU opcode
- ALU_OUT  in  WIDTH  from ALU result
- Arith_flag, Logic_flag, CMP_flag, Shift_flag  in  1 each  from ALU
- RSP_VALID  out  1  response available
- RSP_READY  in  1  consumer accepts response
- RSP_DATA  out  WIDTH  captured result
- RSP_FLAGS  out  4  {Arith,Logic,CMP,Shift} as captured
- RSP_ERR  out  1  error for this response
- OP_COUNT  out  16  completed responses, saturating

Behaviour:
- Reset (RST=0, takes effect immediately, no clock needed):
  - State=IDLE.
  - A=0, B=0, ALU_FUN=4'b1111 (ALU default: zero output, no flags).
  - RSP_VALID=0, RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=0, OP_COUNT=0.
  - Any in-flight command is discarded; no response is produced for it.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  - IDLE: CMD_READY=1 (CMD_READY is 1 only in IDLE). On an edge with CMD_VALID=1, register CMD_A->A, CMD_B->B, CMD_FUN->ALU_FUN; latch a div-by-zero marker (CMD_FUN==4'b0011 and CMD_B==0); go to ISSUE.
  - ISSUE: one cycle. The ALU samples A/B/ALU_FUN at the closing edge. Go to WAIT.
  - WAIT: one cycle. At the closing edge, capture ALU_OUT and the flags, compute RSP_ERR, set RSP_VALID=1, go to RESP.
  - RESP: hold RSP_VALID and all RSP_* stable until an edge with RSP_READY=1. At that edge: RSP_VALID=0, OP_COUNT+1 (holds at 16'hFFFF), go to IDLE.
- Latency: command accepted at edge N, RSP_VALID=1 after edge N+2. Minimum 4 cycles per operation; no overlap.
- A/B/ALU_FUN hold their last issued values until the next accept.
- Expected flag class by opcode:
  - 0000-0011: Arith only.
  - 0100-1001: Logic only.
  - 1010-1100: CMP only.
  - 1101-1110: Shift only.
  - 1111: all zero.
- RSP_ERR=1 when the captured flags differ from the expected one-hot class, OR the div-by-zero marker is set.
- On div-by-zero, RSP_DATA is forced to 0 regardless of ALU_OUT. RSP_FLAGS still show the captured flags.
- Opcode 1111 is legal: it is issued normally and returns data 0, flags 0, RSP_ERR=0.
- CMD_VALID outside IDLE is ignored. The source must hold the packet until the CMD_READY handshake.
- RSP_READY=1 while RSP_VALID=0 has no effect.
- Reset asserted during RESP drops RSP_VALID at once; that response does not count toward OP_COUNT.

Test Plan:
- Reset release, then CMD ADD A=16'h0003 B=16'h0004, RSP_READY=1 -> RSP_VALID rises after accept edge +2; RSP_DATA=16'h0007, RSP_FLAGS=4'b1000, RSP_ERR=0, OP_COUNT=1.
- CMD 1011 with A=5, B=3 -> RSP_DATA=16'h0002, RSP_FLAGS=4'b0010, RSP_ERR=0. Then CMD 1110 with A=16'h8001 -> RSP_DATA=16'h0002, RSP_FLAGS=4'b0001.
- CMD 0011 with A=10, B=0 -> RSP_DATA=0, RSP_ERR=1, RSP_FLAGS=4'b1000, OP_COUNT increments.
- Hold RSP_READY=0 for 5 cycles with CMD_VALID=1 continuously:
  - CMD_READY=0 throughout.
  - RSP_DATA/RSP_FLAGS stable, no second accept.
  - On RSP_READY=1: one handshake, return to IDLE, next command accepted the following edge.
- ALU model forced to return Logic_flag for opcode 0000 -> RSP_ERR=1. Opcode 1111 -> RSP_DATA=0, RSP_FLAGS=0, RSP_ERR=0.
- RST pulsed low during WAIT and again during RESP -> outputs reset immediately, ALU_FUN=4'b1111, OP_COUNT unchanged by the aborted op. Preload OP_COUNT near 16'hFFFF -> saturates at 16'hFFFF.
